sva_verdict_collector: RTL

- Consumer end of the match/fail result interface that the sampled-value checkers ($stable, $rose, ...) produce.
- Observes one checker's match/fail pair over a measurement window.
- Counts passing and failing attempts, timestamps the first failure, flags protocol violations and issues a final verdict.
- Sits beside each checker instance in the assertion test harness.

---
 rtl/sva_pkg.sv | 18 +
 rtl/sva_sat_counter.sv | 36 +++
 rtl/sva_verdict_collector.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sva_pkg.sv
// Shared types for the assertion-harness verdict collector.
package sva_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic pass;
    logic vacuous;
    logic aborted;
    logic proto_err;
    logic sat;
  } verdict_t;

endpackage

// File: rtl/sva_sat_counter.sv
// Saturating up-counter with synchronous clear; saturated_c reports the post-edge value at its ceiling.
module sva_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] value_nxt_c,
  output logic             saturated_c
);

  localparam logic [CNT_W-1:0] MAX_VAL = {CNT_W{1'b1}};

  always_comb begin
    value_nxt_c = value;
    if (clear) begin
      value_nxt_c = '0;
    end else if (inc && (value != MAX_VAL)) begin
      value_nxt_c = value + CNT_W'(1);
    end
  end

  // A saturating counter only leaves its ceiling on clear, so this flag is sticky by construction.
  assign saturated_c = (value_nxt_c == MAX_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      value <= value_nxt_c;
    end
  end

endmodule

// File: rtl/sva_verdict_collector.sv
// Observes one checker's match/fail pair over a window, counts attempts and issues a verdict.
module sva_verdict_collector
  import sva_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FAIL_LIMIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] window_len,
  input  logic             match,
  input  logic             fail,
  output logic             busy,
  output logic             done,
  output logic             verdict_pass,
  output logic             vacuous,
  output logic             aborted,
  output logic             proto_err,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_time,
  output logic             sat
);

  state_e           state, state_nxt;
  verdict_t         res_q, res_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cyc_cnt, cyc_nxt, match_nxt, fail_nxt;
  logic [CNT_W-1:0] fft_nxt;
  logic             ffv_nxt, done_nxt;
  logic             cyc_sat, match_sat, fail_sat;
  logic             run, start_acc, match_inc, fail_inc;
  logic             end_len, abort_hit, close;

  assign run       = (state == RUN);
  assign start_acc = start && !run;
  assign match_inc = run && match && !fail;
  assign fail_inc  = run && fail;

  sva_sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk(clk), .rst_n(rst_n), .clear(start_acc), .inc(run),
    .value(cyc_cnt), .value_nxt_c(cyc_nxt), .saturated_c(cyc_sat)
  );

  sva_sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk(clk), .rst_n(rst_n), .clear(start_acc), .inc(match_inc),
    .value(match_cnt), .value_nxt_c(match_nxt), .saturated_c(match_sat)
  );

  sva_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk(clk), .rst_n(rst_n), .clear(start_acc), .inc(fail_inc),
    .value(fail_cnt), .value_nxt_c(fail_nxt), .saturated_c(fail_sat)
  );

  // Saturated cyc_nxt can only equal a nonzero length the edge it first reaches it, so unbounded windows stay open.
  assign end_len   = (len_q != '0) && (cyc_nxt == len_q);
  assign abort_hit = (FAIL_LIMIT != 0) && (fail_nxt == CNT_W'(FAIL_LIMIT));
  assign close     = run && (stop || end_len || abort_hit);

  always_comb begin
    state_nxt   = state;
    res_nxt     = res_q;
    ffv_nxt     = first_fail_valid;
    fft_nxt     = first_fail_time;
    done_nxt    = 1'b0;
    res_nxt.sat = res_q.sat | cyc_sat | match_sat | fail_sat;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          res_nxt   = '0;
          ffv_nxt   = 1'b0;
          fft_nxt   = '0;
        end
      end
      RUN: begin
        if (fail && match) begin
          res_nxt.proto_err = 1'b1;
        end
        if (fail && !first_fail_valid) begin
          ffv_nxt = 1'b1;
          fft_nxt = cyc_cnt;
        end
        if (close) begin
          state_nxt       = DONE;
          done_nxt        = 1'b1;
          res_nxt.aborted = abort_hit;
          res_nxt.pass    = (fail_nxt == '0) && !res_nxt.proto_err && (match_nxt != '0);
          res_nxt.vacuous = (fail_nxt == '0) && (match_nxt == '0);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      res_q            <= '0;
      len_q            <= '0;
      first_fail_valid <= 1'b0;
      first_fail_time  <= '0;
    end else begin
      state            <= state_nxt;
      busy             <= (state_nxt == RUN);
      done             <= done_nxt;
      res_q            <= res_nxt;
      first_fail_valid <= ffv_nxt;
      first_fail_time  <= fft_nxt;
      if (start_acc) begin
        len_q <= window_len;
      end
    end
  end

  assign verdict_pass = res_q.pass;
  assign vacuous      = res_q.vacuous;
  assign aborted      = res_q.aborted;
  assign proto_err    = res_q.proto_err;
  assign sat          = res_q.sat;

endmodule
